// File: rtl/rv32i_mc_control.sv
// rv32i_mc_control
// Multi-cycle control FSM for the RV32I core. Sequences the shared ALU,
// register file, PC and memory ports through FETCH/DECODE/EXEC/MEM/WB and
// decodes opcode/funct3/instr[30] into the 4-bit ALU control encoding.
//
// Optional feature: define CTRL_PERF_CNT_EN to build the 32-bit
// retired-instruction counter on `instret`; otherwise `instret` is tied to 0.
//
// state  | meaning
// -------+-----------------------------------------------------------
// FETCH  | request instruction, latch opcode/funct3/bit30 on imem_ack
// DECODE | legality check of the latched fields
// EXEC   | drive ALU; branches resolve and update the PC here
// MEM    | data access for lw/sw, held until dmem_ack
// WB     | register write-back and PC update
// TRAP   | illegal instruction seen; sticky until reset
// 6, 7   | unused codes, fall into TRAP on the next edge

module rv32i_mc_control #(
    parameter logic [2:0] RESET_STATE = 3'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic        br_eq,
    input  logic        br_lt,
    input  logic        br_ltu,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_sel,
    output logic [3:0]  alu_ctrl,
    output logic        alu_src_b,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        illegal,
    output logic [2:0]  state,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    state_t     state_q;
    logic [6:0] op_q;
    logic [2:0] f3_q;
    logic       b30_q;

    logic       is_r;
    logic       is_i;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
    logic       is_jal;
    logic       is_jalr;
    logic       is_lui;
    logic       legal;
    logic       br_taken;
    logic [3:0] alu_op;

    // Only opcode, funct3 and bit 30 steer control; the rest of the word
    // belongs to the datapath (register indices, immediates).
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    assign is_r      = (op_q == OP_R);
    assign is_i      = (op_q == OP_I);
    assign is_load   = (op_q == OP_LOAD);
    assign is_store  = (op_q == OP_STORE);
    assign is_branch = (op_q == OP_BRANCH);
    assign is_jal    = (op_q == OP_JAL);
    assign is_jalr   = (op_q == OP_JALR);
    assign is_lui    = (op_q == OP_LUI);

    // funct3 010/011 are unassigned branch encodings
    assign legal = is_r || is_i || is_load || is_store || is_jal || is_jalr || is_lui
                   || (is_branch && (f3_q[2:1] != 2'b01));

    // ALU operation from the latched fields; bit 30 only matters for sub/sra
    always_comb begin
        alu_op = ALU_ADD;
        if (is_r || is_i) begin
            case (f3_q)
                3'b000:  alu_op = (is_r && b30_q) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_op = ALU_SLL;
                3'b010:  alu_op = ALU_SLT;
                3'b011:  alu_op = ALU_SLTU;
                3'b100:  alu_op = ALU_XOR;
                3'b101:  alu_op = b30_q ? ALU_SRA : ALU_SRL;
                3'b110:  alu_op = ALU_OR;
                default: alu_op = ALU_AND;
            endcase
        end else if (is_branch) begin
            alu_op = ALU_SUB;
        end
    end

    // Branch resolution from the comparator flags
    always_comb begin
        case (f3_q)
            3'b000:  br_taken = br_eq;
            3'b001:  br_taken = !br_eq;
            3'b100:  br_taken = br_lt;
            3'b101:  br_taken = !br_lt;
            3'b110:  br_taken = br_ltu;
            3'b111:  br_taken = !br_ltu;
            default: br_taken = 1'b0;
        endcase
    end

    // State register and latched instruction fields
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= state_t'(RESET_STATE);
            op_q    <= '0;
            f3_q    <= '0;
            b30_q   <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_ack) begin
                        op_q    <= instr[6:0];
                        f3_q    <= instr[14:12];
                        b30_q   <= instr[30];
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    state_q <= legal ? S_EXEC : S_TRAP;
                end
                S_EXEC: begin
                    if (is_branch) begin
                        state_q <= S_FETCH;
                    end else if (is_load || is_store) begin
                        state_q <= S_MEM;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        state_q <= is_store ? S_FETCH : S_WB;
                    end
                end
                S_WB: begin
                    state_q <= S_FETCH;
                end
                S_TRAP: begin
                    state_q <= S_TRAP;
                end
                default: begin
                    state_q <= S_TRAP;
                end
            endcase
        end
    end

    // Control outputs decoded from the registered state; forced to 0 while
    // rst is high so a mid-instruction reset kills any pending pulse at once.
    always_comb begin
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = 1'b0;
        alu_ctrl  = ALU_ADD;
        alu_src_b = 1'b0;
        reg_we    = 1'b0;
        wb_sel    = 2'b00;
        illegal   = 1'b0;
        state     = 3'd0;
        if (!rst) begin
            state = state_q;
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ack;
                end
                S_EXEC: begin
                    alu_ctrl  = alu_op;
                    alu_src_b = !(is_r || is_branch);
                    if (is_branch) begin
                        pc_we  = 1'b1;
                        pc_sel = br_taken;
                    end
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = is_store;
                    pc_we    = is_store && dmem_ack;
                end
                S_WB: begin
                    reg_we = 1'b1;
                    pc_we  = 1'b1;
                    pc_sel = is_jal || is_jalr;
                    if (is_load) begin
                        wb_sel = 2'b01;
                    end else if (is_jal || is_jalr) begin
                        wb_sel = 2'b10;
                    end else if (is_lui) begin
                        wb_sel = 2'b11;
                    end
                end
                S_TRAP: begin
                    illegal = 1'b1;
                end
                default: begin
                    illegal = 1'b0;
                end
            endcase
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] instret_q;

    // Retired-instruction counter: one count per PC update, wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_q <= '0;
        end else if (pc_we && (state_q != S_TRAP)) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

endmodule

// File: doc/rv32i_mc_control.md
# rv32i_mc_control

Multi-cycle control FSM for the RV32I core. It sequences a single shared ALU, register file, PC register and instruction/data memory ports through the FETCH, DECODE, EXEC, MEM and WB steps, and handshakes with both memories. It decodes opcode, funct3 and instr[30] into the team's 4-bit ALU control encoding. It sits between the memory interfaces and the existing datapath, replacing the single-cycle combinational controller.

## Interface
Parameters:
- `RESET_STATE`, default 3'd0 (FETCH): state entered on reset.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `instr` in 32: instruction word from imem; sampled when `imem_ack` is high in FETCH.
- `imem_req` out 1 / `imem_ack` in 1: instruction fetch handshake.
- `dmem_req` out 1 / `dmem_we` out 1 / `dmem_ack` in 1: data access handshake.
- `br_eq`, `br_lt`, `br_ltu` in 1 each: comparator flags for rs1 vs rs2.
- `ir_we` out 1: latch `instr` into the datapath IR.
- `pc_we` out 1: update the PC.
- `pc_sel` out 1: PC source; 0 = PC+4, 1 = target.
- `alu_ctrl` out 4: ALU operation.
- `alu_src_b` out 1: ALU operand B; 0 = rs2, 1 = immediate.
- `reg_we` out 1: register file write enable.
- `wb_sel` out 2: write-back source; 00 = ALU, 01 = memory, 10 = PC+4, 11 = immediate (LUI).
- `illegal` out 1: sticky trap flag.
- `state` out 3: current FSM state, for debug.
- `instret` out 32: retired-instruction count (see Configuration).

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6 and 7 go to TRAP.
- **FETCH:** `imem_req`=1 until `imem_ack`. On ack: `ir_we`=1 for that cycle, the internal opcode/funct3/bit30 copy is latched, next state is DECODE.
- **DECODE:** one cycle.
  - Supported opcodes: 0110011, 0010011, 0000011 (lw), 0100011 (sw), 1100011, 1101111, 1100111, 0110111.
  - Any other opcode goes to TRAP.
  - Branch funct3 010 or 011 goes to TRAP.
- **EXEC:** `alu_ctrl` and `alu_src_b` are driven.
  - Branch: `pc_we`=1. `pc_sel` = taken (beq=eq, bne=!eq, blt=lt, bge=!lt, bltu=ltu, bgeu=!ltu). Next state is FETCH.
  - Load/store: next state is MEM.
  - All others: next state is WB.
- **MEM:** `dmem_req`=1 until `dmem_ack`; `dmem_we`=1 for stores.
  - Store ack: `pc_we`=1, `pc_sel`=0, next state is FETCH.
  - Load ack: next state is WB.
- **WB:** `reg_we`=1, `pc_we`=1, `pc_sel`=1 for JAL/JALR, else 0. Next state is FETCH.
- **TRAP:** `illegal`=1 and all other control outputs 0. Left only by reset.
- `alu_ctrl` encoding: add 0000, sub 0001, sll 0010, slt 0011, sltu 0100, xor 0101, srl 0110, sra 0111, or 1000, and 1001.
  - R-type: funct3 plus instr[30]; instr[30] selects sub/sra.
  - I-ALU: instr[30] is honoured only for funct3=101 (srai); addi with bit30 set is add.
  - Load, store, JAL, JALR, LUI: add. Branch: sub.
- Control outputs are 0 in every state where they are not listed above.

## Timing
- While `rst`=1, every output is 0 and `state`=0. The first cycle after release is FETCH with `imem_req`=1.
- Mealy paths, allowed by design: `ir_we` follows `imem_ack` in FETCH; store `pc_we` follows `dmem_ack` in MEM. All other outputs depend only on state and the latched fields.
- `imem_ack` outside FETCH and `dmem_ack` outside MEM are ignored.
- Zero-wait ack (in the first request cycle) is legal.
- Minimum cycles per instruction: branch 3, R/I/JAL/JALR/LUI 4, store 4, load 5. Each wait cycle adds one.
- Once asserted, a request stays high and its attributes stay stable until ack.
- Reset asserted mid-instruction aborts it immediately, with no `reg_we` or `pc_we` pulse.

## Configuration
- `CTRL_PERF_CNT_EN` defined: `instret` is a 32-bit counter.
  - Clears on reset.
  - Increments on every `pc_we` cycle outside TRAP.
  - Wraps from 0xFFFFFFFF to 0.
- `CTRL_PERF_CNT_EN` undefined: `instret` is tied to 0 and no counter flops exist.

## Test plan
- `add` (0x002081B3), zero-wait acks -> states 0,1,2,4,0. In WB: `alu_ctrl`=0000, `reg_we`=1, `wb_sel`=00, `pc_sel`=0.
- `sub` with 2-cycle `imem_ack` delay -> `imem_req` high for 3 cycles, `ir_we` only on the ack cycle, `alu_ctrl`=0001, 6 cycles total.
- `lw` with `dmem_ack` 3 cycles late -> `dmem_we`=0, then WB with `wb_sel`=01. `srai` -> `alu_ctrl`=0111; `addi` with bit30 set -> `alu_ctrl`=0000.
- `bne` with `br_eq`=0 -> `pc_we`=1, `pc_sel`=1 in EXEC, 3 cycles. With `br_eq`=1 -> `pc_sel`=0.
- Opcode 0x7F -> TRAP and `illegal`=1, held until `rst`. Reset pulse in MEM -> `state`=0 and outputs 0 within the same cycle.
- With `CTRL_PERF_CNT_EN` defined, 5 retired instructions -> `instret`=5. The counter preset to 0xFFFFFFFF wraps to 0.
